bram_s8_arbiter: RTL and testbench

- Shares one 512x8 single-port block RAM (1-cycle registered read, write-first output) between two requesters, A and B.
- Round-robin arbitration issues at most one RAM operation per cycle.
- Read data is returned with a per-requester valid strobe.
- Also provides a sequenced clear that writes zero to all 512 locations.
- Sits between the RAM primitive and the client logic.

---
 rtl/bram_s8_arbiter.sv | 115 +++++++++++
 tb/tb_bram_s8_arbiter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/bram_s8_arbiter.sv
// bram_s8_arbiter: round-robin A/B access to one 512x8 single-port RAM,
// plus a sequenced clear that writes CLR_VAL to every word.
module bram_s8_arbiter #(
  parameter int          DEPTH   = 512,
  parameter logic [7:0]  CLR_VAL = 8'h00
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       A_REQ,
  input  logic       A_WE,
  input  logic [8:0] A_ADDR,
  input  logic [7:0] A_DI,
  output logic       A_GNT,
  output logic       A_VLD,
  input  logic       B_REQ,
  input  logic       B_WE,
  input  logic [8:0] B_ADDR,
  input  logic [7:0] B_DI,
  output logic       B_GNT,
  output logic       B_VLD,
  output logic [7:0] RDATA,
  input  logic       CLR,
  output logic       BUSY,
  output logic [8:0] RAM_ADDR,
  output logic [7:0] RAM_DI,
  output logic       RAM_EN,
  output logic       RAM_WE,
  input  logic [7:0] RAM_DO
);
  typedef enum logic {RUN, CLEAR} state_t;
  state_t     state_q, state_d;
  logic [8:0] cnt_q, cnt_d, addr_q, addr_d;
  logic [7:0] di_q, di_d;
  logic       ptr_q, ptr_d;
  logic       a_gnt_q, a_gnt_d, b_gnt_q, b_gnt_d;
  logic       a_vld_q, a_vld_d, b_vld_q, b_vld_d;
  logic       busy_q, busy_d, en_q, en_d, we_q, we_d;
  logic       a_win, b_win, last;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    addr_d  = addr_q;
    di_d    = di_q;
    a_gnt_d = 1'b0;
    b_gnt_d = 1'b0;
    busy_d  = 1'b0;
    en_d    = 1'b0;
    we_d    = 1'b0;
    last    = 1'b0;
    // a read granted last cycle is in the RAM now; flag its data next cycle
    a_vld_d = a_gnt_q & ~we_q;
    b_vld_d = b_gnt_q & ~we_q;
    // ptr_q = 1 gives B priority when both request
    a_win   = A_REQ & (~B_REQ | ~ptr_q);
    b_win   = B_REQ & ~a_win;
    if (state_q == CLEAR || CLR) begin
      busy_d  = 1'b1;
      en_d    = 1'b1;
      we_d    = 1'b1;
      di_d    = CLR_VAL;
      addr_d  = (state_q == CLEAR) ? cnt_q : '0;
      last    = (addr_d == 9'(DEPTH - 1));
      cnt_d   = last ? '0 : addr_d + 9'd1;
      state_d = last ? RUN : CLEAR;
    end else if (a_win || b_win) begin
      en_d    = 1'b1;
      we_d    = a_win ? A_WE : B_WE;
      addr_d  = a_win ? A_ADDR : B_ADDR;
      di_d    = a_win ? A_DI : B_DI;
      a_gnt_d = a_win;
      b_gnt_d = b_win;
      ptr_d   = a_win;
    end
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= RUN;
      cnt_q   <= '0;
      ptr_q   <= 1'b0;
      addr_q  <= '0;
      di_q    <= '0;
      a_gnt_q <= 1'b0;
      b_gnt_q <= 1'b0;
      a_vld_q <= 1'b0;
      b_vld_q <= 1'b0;
      busy_q  <= 1'b0;
      en_q    <= 1'b0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      addr_q  <= addr_d;
      di_q    <= di_d;
      a_gnt_q <= a_gnt_d;
      b_gnt_q <= b_gnt_d;
      a_vld_q <= a_vld_d;
      b_vld_q <= b_vld_d;
      busy_q  <= busy_d;
      en_q    <= en_d;
      we_q    <= we_d;
    end
  end
  assign A_GNT    = a_gnt_q;
  assign B_GNT    = b_gnt_q;
  assign A_VLD    = a_vld_q;
  assign B_VLD    = b_vld_q;
  assign BUSY     = busy_q;
  assign RAM_EN   = en_q;
  assign RAM_WE   = we_q;
  assign RAM_ADDR = addr_q;
  assign RAM_DI   = di_q;
  assign RDATA    = RAM_DO;
endmodule

// File: tb/tb_bram_s8_arbiter.sv
// tb_bram_s8_arbiter: directed and random stimulus against a cycle-level
// reference model of the arbiter, with a behavioural 512x8 RAM attached.
module tb_bram_s8_arbiter;
  logic       CLK = 1'b0, RST = 1'b1;
  logic       A_REQ, A_WE, B_REQ, B_WE, CLR;
  logic [8:0] A_ADDR, B_ADDR;
  logic [7:0] A_DI, B_DI;
  logic       A_GNT, A_VLD, B_GNT, B_VLD, BUSY, RAM_EN, RAM_WE;
  logic [7:0] RDATA, RAM_DI;
  logic [8:0] RAM_ADDR;
  logic [7:0] RAM_DO = 8'h00;
  logic [7:0] ram [512];

  bram_s8_arbiter dut (
    .CLK(CLK), .RST(RST),
    .A_REQ(A_REQ), .A_WE(A_WE), .A_ADDR(A_ADDR), .A_DI(A_DI), .A_GNT(A_GNT), .A_VLD(A_VLD),
    .B_REQ(B_REQ), .B_WE(B_WE), .B_ADDR(B_ADDR), .B_DI(B_DI), .B_GNT(B_GNT), .B_VLD(B_VLD),
    .RDATA(RDATA), .CLR(CLR), .BUSY(BUSY),
    .RAM_ADDR(RAM_ADDR), .RAM_DI(RAM_DI), .RAM_EN(RAM_EN), .RAM_WE(RAM_WE), .RAM_DO(RAM_DO)
  );

  always #5 CLK = ~CLK;

  // write-first single-port RAM with registered output
  always @(posedge CLK)
    if (RAM_EN) begin
      if (RAM_WE) begin
        ram[RAM_ADDR] <= RAM_DI;
        RAM_DO        <= RAM_DI;
      end else RAM_DO <= ram[RAM_ADDR];
    end

  int passed = 0, total = 0, fails = 0, n;
  logic [7:0] mref [512];
  bit         turn_b, e_rst, e_ga, e_gb, e_va, e_vb, e_busy, e_we, p_rda, p_rdb;
  int         clr_left;
  logic [8:0] e_addr;
  logic [7:0] e_di, e_rd, p_data;
  logic [1:0] rr_pat [4] = '{2'b10, 2'b01, 2'b10, 2'b01};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Predict the effect of the coming edge from the driven inputs, then check.
  task automatic tick();
    bit na, nb;
    e_rst = RST;
    if (RST) begin
      {e_ga, e_gb, e_va, e_vb, e_busy, p_rda, p_rdb, turn_b} = '0;
      clr_left = 0;
    end else begin
      e_va = p_rda;
      e_vb = p_rdb;
      e_rd = p_data;
      {e_ga, e_gb, e_busy, p_rda, p_rdb} = '0;
      if (clr_left > 0 || CLR) begin
        if (clr_left == 0) clr_left = 512;
        e_busy = 1;
        e_addr = 9'(512 - clr_left);
        mref[e_addr] = 8'h00;
        clr_left--;
      end else begin
        na = A_REQ && (!B_REQ || !turn_b);
        nb = B_REQ && !na;
        if (na || nb) begin
          turn_b = na;
          e_addr = na ? A_ADDR : B_ADDR;
          e_we   = na ? A_WE : B_WE;
          e_di   = na ? A_DI : B_DI;
          if (e_we) mref[e_addr] = e_di;
          else p_data = mref[e_addr];
          p_rda = na && !e_we;
          p_rdb = nb && !e_we;
          e_ga = na;
          e_gb = nb;
        end
      end
    end
    @(posedge CLK);
    #1;
    if (e_rst) begin
      chk("rst_en", 32'(RAM_EN), 0);
      chk("rst_we", 32'(RAM_WE), 0);
      chk("rst_addr", 32'(RAM_ADDR), 0);
      chk("rst_di", 32'(RAM_DI), 0);
    end
    chk("a_gnt", 32'(A_GNT), 32'(e_ga));
    chk("b_gnt", 32'(B_GNT), 32'(e_gb));
    chk("a_vld", 32'(A_VLD), 32'(e_va));
    chk("b_vld", 32'(B_VLD), 32'(e_vb));
    chk("busy", 32'(BUSY), 32'(e_busy));
    if (e_va || e_vb) chk("rdata", 32'(RDATA), 32'(e_rd));
    if (e_busy) begin
      chk("clr_ram_addr", 32'(RAM_ADDR), 32'(e_addr));
      chk("clr_ram_we", 32'({RAM_EN, RAM_WE, RAM_DI}), 32'h300);
    end
    if (e_ga || e_gb) begin
      chk("op_addr", 32'(RAM_ADDR), 32'(e_addr));
      chk("op_en_we", 32'({RAM_EN, RAM_WE}), 32'({1'b1, e_we}));
      if (e_we) chk("op_di", 32'(RAM_DI), 32'(e_di));
    end
  endtask

  initial begin
    {A_REQ, A_WE, B_REQ, B_WE, CLR} = '0;
    {A_ADDR, B_ADDR, A_DI, B_DI} = '0;
    tick();
    tick();
    RST = 0;
    // write then read the same word
    A_REQ = 1; A_WE = 1; A_ADDR = 9'h010; A_DI = 8'h5A; tick();
    A_WE = 0; tick();
    A_REQ = 0; tick();
    chk("wr_rd_vld", 32'(A_VLD), 1);
    chk("wr_rd_data", 32'(RDATA), 32'h5A);
    // preload, then both read continuously: strict alternation
    A_REQ = 1; A_WE = 1; A_ADDR = 9'h001; A_DI = 8'h11; tick();
    A_REQ = 0; B_REQ = 1; B_WE = 1; B_ADDR = 9'h002; B_DI = 8'h22; tick();
    A_WE = 0; B_WE = 0; A_REQ = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rr_gnt", 32'({A_GNT, B_GNT}), 32'(rr_pat[i]));
      if (i > 0) chk("rr_data", 32'(RDATA), (i % 2 == 1) ? 32'h11 : 32'h22);
    end
    A_REQ = 0; B_REQ = 0; tick(); tick();
    // full clear over a freshly written top word
    A_REQ = 1; A_WE = 1; A_ADDR = 9'h1FF; A_DI = 8'hFF; tick();
    A_REQ = 0; CLR = 1; n = 0;
    for (int i = 0; i < 512; i++) begin
      tick();
      CLR = 0;
      if (BUSY) n++;
      chk("clr_step", 32'(RAM_ADDR), 32'(i));
    end
    tick();
    chk("busy_len", 32'(n), 512);
    chk("busy_end", 32'(BUSY), 0);
    A_REQ = 1; A_WE = 0; A_ADDR = 9'h1FF; tick();
    A_REQ = 0; tick();
    chk("clr_rd", 32'({A_VLD, RDATA}), 32'h100);
    // request at the same edge as CLR waits for the clear
    B_REQ = 1; B_WE = 0; B_ADDR = 9'h002; CLR = 1; n = 0;
    do begin
      tick();
      CLR = 0;
      n++;
    end while (!e_gb && n < 600);
    chk("clr_b_wait", 32'(n), 513);
    chk("clr_b_gnt", 32'({B_GNT, BUSY}), 32'b10);
    B_REQ = 0; tick(); tick();
    // reset aborts a clear part-way
    A_REQ = 1; A_WE = 1; A_ADDR = 9'h000; A_DI = 8'h33; tick();
    A_ADDR = 9'h150; A_DI = 8'h77; tick();
    A_REQ = 0; CLR = 1;
    for (int i = 0; i < 100; i++) begin
      tick();
      CLR = 0;
    end
    chk("abort_addr", 32'(RAM_ADDR), 32'd99);
    RST = 1; tick();
    RST = 0;
    chk("abort_busy", 32'(BUSY), 0);
    A_REQ = 1; A_WE = 0; A_ADDR = 9'h000; tick();
    A_ADDR = 9'h150; tick();
    A_REQ = 0;
    chk("abort_rd0", 32'({A_VLD, RDATA}), 32'h100);
    tick();
    chk("abort_keep", 32'({A_VLD, RDATA}), 32'h177);
    // single requester, back-to-back reads
    A_REQ = 1; A_WE = 0;
    for (int i = 0; i < 4; i++) begin
      A_ADDR = 9'(9'h150 + i);
      if (i == 3) A_REQ = 0;
      tick();
      chk("seq_gnt", 32'(A_GNT), 32'(i < 3));
      chk("seq_vld", 32'(A_VLD), 32'(i > 0));
    end
    tick();
    // random traffic
    for (int c = 0; c < 400; c++) begin
      if (!A_REQ || e_ga) begin
        A_REQ  = $urandom_range(0, 2) != 0;
        A_WE   = 1'($urandom_range(0, 1));
        A_ADDR = ($urandom_range(0, 3) == 0) ? 9'h1FF : 9'($urandom_range(0, 7));
        A_DI   = 8'($urandom);
      end
      if (!B_REQ || e_gb) begin
        B_REQ  = $urandom_range(0, 2) != 0;
        B_WE   = 1'($urandom_range(0, 1));
        B_ADDR = ($urandom_range(0, 3) == 0) ? 9'h1FF : 9'($urandom_range(0, 7));
        B_DI   = 8'($urandom);
      end
      tick();
    end
    A_REQ = 0; B_REQ = 0; tick(); tick();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
